// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the multi-precision add/sub sequencer.
//    state_t  - sequencer state encoding (IDLE, RUN, DONE)
//    MODE_ADD - mode value selecting A+B
//    MODE_SUB - mode value selecting A-B
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: W-bit generate/propagate add/subtract cell with a separate
// carry-in so that several slices (or one slice over time) can be chained.
//    a, b   in  W  operands; b is inverted when m selects subtract
//    m      in  1  mode (MODE_ADD / MODE_SUB)
//    cin    in  1  carry into bit 0 (the subtract +1 is supplied here by the caller)
//    s      out W  slice sum modulo 2^W
//    cout   out 1  carry out of bit W-1
//    c_msb  out 1  carry into bit W-1 (for signed overflow detection)
module addsub_slice
   import addsub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         m,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         c_msb
);

   logic [W-1:0] w_bx;
   logic [W-1:0] w_g;
   logic [W-1:0] w_p;
   logic [W:0]   w_c;

   always_comb begin
      w_bx   = b ^ {W{m == MODE_SUB}};
      w_g    = a & w_bx;
      w_p    = a ^ w_bx;
      w_c    = '0;
      w_c[0] = cin;
      for (int unsigned i = 0; i < W; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
      s     = w_p ^ w_c[W-1:0];
      cout  = w_c[W];
      c_msb = w_c[W-1];
   end

endmodule

// File: rtl/addsub_mp_seq.sv
// addsub_mp_seq: multi-precision add/subtract sequencer. Operands of W*N bits
// are pushed LSB slice first through one shared W-bit addsub_slice, one slice
// per clock, with the carry chained between slices in a 1-bit register.
//    clk     in   1    rising-edge clock
//    rst     in   1    synchronous active-high reset
//    start   in   1    request, accepted only while ready=1
//    m       in   1    0 = A+B, 1 = A-B (sampled on accept)
//    op_a    in   W*N  operand A (sampled on accept)
//    op_b    in   W*N  operand B (sampled on accept)
//    ready   out  1    high in IDLE
//    busy    out  1    high in RUN
//    done    out  1    one-cycle pulse when result/cout/ovf are valid
//    result  out  W*N  sum or difference, held until next accept
//    cout    out  1    carry out of MSB (subtract: 1 = no borrow)
//    ovf     out  1    signed overflow of the full-width operation
//    zero    out  1    whole result is zero (only with ADDSUB_MP_ZERO_FLAG_EN)
// Optional feature macro: ADDSUB_MP_ZERO_FLAG_EN adds the zero output.
module addsub_mp_seq
   import addsub_pkg::*;
#(
   parameter int W = 4,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           m,
   input  logic [W*N-1:0] op_a,
   input  logic [W*N-1:0] op_b,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [W*N-1:0] result,
   output logic           cout,
   output logic           ovf
`ifdef ADDSUB_MP_ZERO_FLAG_EN
   ,
   output logic           zero
`endif
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_t           r_state;
   logic [W*N-1:0]   r_a;
   logic [W*N-1:0]   r_b;
   logic             r_m;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic [W*N-1:0]   r_result;
   logic             r_cout;
   logic             r_ovf;

   logic [W-1:0]     w_a_sl;
   logic [W-1:0]     w_b_sl;
   logic [W-1:0]     w_s;
   logic             w_cout;
   logic             w_c_msb;
   logic             w_last;

   // Slice multiplexer: pick the current W-bit slice of each latched operand.
   always_comb begin
      w_a_sl = '0;
      w_b_sl = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_sl = r_a[k*W +: W];
            w_b_sl = r_b[k*W +: W];
         end
      end
      w_last = (r_idx == IDX_W'(N-1));
   end

   addsub_slice #(.W(W)) u_slice (
      .a     (w_a_sl),
      .b     (w_b_sl),
      .m     (r_m),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout),
      .c_msb (w_c_msb)
   );

`ifdef ADDSUB_MP_ZERO_FLAG_EN
   logic r_zacc;
   logic r_zero;
   logic w_zacc_next;

   // Sticky all-zero accumulator; restarts at the first slice of each run.
   always_comb begin
      w_zacc_next = ((r_idx == '0) ? 1'b1 : r_zacc) & (w_s == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zacc <= 1'b0;
         r_zero <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_zacc <= w_zacc_next;
         if (w_last) begin
            r_zero <= w_zacc_next;
         end
      end
   end

   assign zero = r_zero;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_m      <= MODE_ADD;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_m     <= m;
                  r_idx   <= '0;
                  // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
                  r_carry <= (m == MODE_SUB);
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int unsigned k = 0; k < N; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     r_result[k*W +: W] <= w_s;
                  end
               end
               r_carry <= w_cout;
               if (w_last) begin
                  r_cout  <= w_cout;
                  r_ovf   <= w_c_msb ^ w_cout;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ready  = (r_state == ST_IDLE);
   assign busy   = (r_state == ST_RUN);
   assign done   = (r_state == ST_DONE);
   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_addsub_mp_seq.sv
module tb_addsub_mp_seq;

   localparam int W   = 4;
   localparam int N   = 4;
   localparam int OPW = W*N;

   logic           clk;
   logic           rst;
   logic           start;
   logic           m;
   logic [OPW-1:0] op_a;
   logic [OPW-1:0] op_b;
   logic           ready;
   logic           busy;
   logic           done;
   logic [OPW-1:0] result;
   logic           cout;
   logic           ovf;
   logic           zero;

   logic           start1;
   logic           m1;
   logic [W-1:0]   a1;
   logic [W-1:0]   b1;
   logic           ready1;
   logic           busy1;
   logic           done1;
   logic [W-1:0]   res1;
   logic           cout1;
   logic           ovf1;
   logic           zero1;

   int n_cmp = 0;
   int n_err = 0;

   addsub_mp_seq #(.W(W), .N(N)) u_dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .m      (m),
      .op_a   (op_a),
      .op_b   (op_b),
      .ready  (ready),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
`ifdef ADDSUB_MP_ZERO_FLAG_EN
      ,
      .zero   (zero)
`endif
   );

   addsub_mp_seq #(.W(W), .N(1)) u_dut1 (
      .clk    (clk),
      .rst    (rst),
      .start  (start1),
      .m      (m1),
      .op_a   (a1),
      .op_b   (b1),
      .ready  (ready1),
      .busy   (busy1),
      .done   (done1),
      .result (res1),
      .cout   (cout1),
      .ovf    (ovf1)
`ifdef ADDSUB_MP_ZERO_FLAG_EN
      ,
      .zero   (zero1)
`endif
   );

`ifndef ADDSUB_MP_ZERO_FLAG_EN
   assign zero  = 1'b0;
   assign zero1 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic           m;
      logic [OPW-1:0] res;
      logic           co;
      logic           ov;
      logic           z;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // Waits for done (sampled on falling edges); k counts cycles since the
   // accept edge, with k=1 being the cycle right after it.
   task automatic wait_done(output int k);
      k = 1;
      while (done !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic run_vec(input int i);
      int k;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      op_a  = vecs[i].a;
      op_b  = vecs[i].b;
      m     = vecs[i].m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op_a  = 16'($urandom);
      op_b  = 16'($urandom);
      m     = ~vecs[i].m;
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(k);
      chk($sformatf("v%0d_lat", i), 32'(k), 32'(N+1));
      chk($sformatf("v%0d_res", i), 32'(result), 32'(vecs[i].res));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].co));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`ifdef ADDSUB_MP_ZERO_FLAG_EN
      chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].z));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
   endtask

   initial begin
      int k;
      vecs[0] = '{a:16'h1234, b:16'h0FCD, m:1'b0, res:16'h2201, co:1'b0, ov:1'b0, z:1'b0};
      vecs[1] = '{a:16'h0005, b:16'h0007, m:1'b1, res:16'hFFFE, co:1'b0, ov:1'b0, z:1'b0};
      vecs[2] = '{a:16'h1234, b:16'h1234, m:1'b1, res:16'h0000, co:1'b1, ov:1'b0, z:1'b1};
      vecs[3] = '{a:16'h7FFF, b:16'h0001, m:1'b0, res:16'h8000, co:1'b0, ov:1'b1, z:1'b0};
      vecs[4] = '{a:16'h8000, b:16'h0001, m:1'b1, res:16'h7FFF, co:1'b1, ov:1'b1, z:1'b0};
      vecs[5] = '{a:16'hFFFF, b:16'h0001, m:1'b0, res:16'h0000, co:1'b1, ov:1'b0, z:1'b1};
      vecs[6] = '{a:16'h0000, b:16'h0000, m:1'b1, res:16'h0000, co:1'b1, ov:1'b0, z:1'b1};
      vecs[7] = '{a:16'hABCD, b:16'h1111, m:1'b0, res:16'hBCDE, co:1'b0, ov:1'b0, z:1'b0};

      rst = 1'b1; start = 1'b0; m = 1'b0; op_a = '0; op_b = '0;
      start1 = 1'b0; m1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);

      for (int i = 0; i < 8; i++) run_vec(i);

      // start held high through RUN and DONE: ignored until the next IDLE
      @(negedge clk);
      op_a = 16'h00FF; op_b = 16'h0001; m = 1'b0; start = 1'b1;
      @(negedge clk);
      op_a = 16'hFFFF;
      wait_done(k);
      chk("hold_lat1", 32'(k), 32'(N+1));
      chk("hold_res1", 32'(result), 32'h0100);
      chk("hold_cout1", 32'(cout), 32'd0);
      chk("hold_ready_in_done", 32'(ready), 32'd0);
      @(negedge clk);
      chk("hold_idle_ready", 32'(ready), 32'd1);
      @(negedge clk);
      chk("hold_reaccept_busy", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done(k);
      chk("hold_lat2", 32'(k), 32'(N+1));
      chk("hold_res2", 32'(result), 32'h0000);
      chk("hold_cout2", 32'(cout), 32'd1);

      // Reset while RUN is at slice index 2; prior cout=1 must clear
      @(negedge clk);
      op_a = 16'h1234; op_b = 16'h0FCD; m = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      k = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done === 1'b1) k++;
      end
      chk("abort_no_done", 32'(k), 32'd0);

      // N=1 instance: single RUN cycle
      @(negedge clk);
      a1 = 4'h7; b1 = 4'h1; m1 = 1'b0; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = 4'h0; b1 = 4'h0;
      k = 1;
      while (done1 !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("n1_lat", 32'(k), 32'd2);
      chk("n1_res", 32'(res1), 32'h8);
      chk("n1_cout", 32'(cout1), 32'd0);
      chk("n1_ovf", 32'(ovf1), 32'd1);
      chk("n1_zero", 32'(zero1), 32'd0);
      @(negedge clk);
      chk("n1_ready", 32'(ready1), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
